spi_rx_capture: RTL and testbench
=================================

// Module: spi_rx_capture
// PURPOSE
//  Receiving end of the debug SPI link. Deserialises one sck/cs/mosi lane into
//  WIDTH-bit words (MSB first), checks frame length and buffers words in a small
//  FIFO with a valid/ready pop port. Used on the capture board, or looped back
//  in simulation, to recover pc, imem data and dmem wdata/rdata debug words.
//  sck, cs and mosi arrive asynchronous to clk and are synchronised inside.
// PARAMETERS
//  WIDTH        32  bits per frame / output word width
//  DEPTH        4   FIFO depth in words; power of two, >= 2
//  SYNC_STAGES  2   flip-flop synchroniser depth on sck, cs and mosi; >= 2
// PORTS
//  clk          in   1              system clock; must run >= 8x sck frequency
//  rst_n        in   1              asynchronous, active-low reset
//  sck          in   1              serial clock from the transmitter
//  cs           in   1              chip select, active low, frames one word
//  mosi         in   1              serial data; transmitter changes it on falling sck
//  word_data    out  WIDTH          FIFO head word; valid only while word_valid=1
//  word_valid   out  1              FIFO not empty
//  word_ready   in   1              consumer accepts head when word_valid & word_ready
//  level        out  $clog2(DEPTH)+1 words currently held, 0..DEPTH
//  frame_err    out  1              one-cycle pulse: frame ended with bit count != WIDTH
//  overflow     out  1              sticky: a good word was dropped because the FIFO was full
//  overflow_clr in   1              clears overflow; a drop in the same cycle wins, flag stays 1
// BEHAVIOUR
//  Reset: sync chains load sck=0, cs=1, mosi=0; FSM=IDLE; bit_cnt=0; FIFO empty;
//   word_valid=0, level=0, frame_err=0, overflow=0, word_data=0.
//  Sync: sck, cs, mosi each pass through SYNC_STAGES flops of equal depth, so
//   the edge detect and the data sample stay aligned. One extra flop per signal
//   holds the previous value: rise = !prev & cur, fall = prev & !cur.
//  FSM:
//   IDLE  -> SHIFT on a synced cs fall; clear bit_cnt and the shift register.
//            A cs that is already low when reset ends is ignored until cs
//            goes high and then falls again.
//   SHIFT -> on each synced sck rise: sr <= {sr[WIDTH-2:0], mosi_s};
//            bit_cnt <= bit_cnt + 1.
//            An sck rise while bit_cnt==WIDTH -> DRAIN (too many bits).
//            On a synced cs rise: bit_cnt==WIDTH -> push sr, go IDLE;
//            otherwise pulse frame_err, go IDLE (covers zero bits too).
//   DRAIN -> ignore sck; on cs rise pulse frame_err, go IDLE; nothing is pushed.
//   If a cs rise and an sck rise land in the same cycle, cs wins and the sck
//   edge is discarded.
//  bit_cnt is $clog2(WIDTH)+1 bits wide and saturates at WIDTH.
//  Latency: word_valid rises SYNC_STAGES+2 clk cycles after the cs pin rises,
//   when the FIFO was empty. frame_err pulses at the same point.
//  FIFO: circular buffer; rd/wr pointers are one bit wider than the index, with
//   wrap. word_data is driven from the head entry (no read latency).
//   Pop happens when word_valid & word_ready.
//   Push with the FIFO full and no pop: word dropped, overflow <= 1, level stays DEPTH.
//   Push with the FIFO full and a pop in the same cycle: both take effect,
//    level stays DEPTH, no overflow.
//   Push and pop together when not full: level unchanged.
//   word_ready while empty: no effect.
//  Reset mid-frame: the partial word and all FIFO contents are discarded, and
//   the FSM returns to IDLE.
// TESTING
//  1 cs low, 32 clocks of 0xDEADBEEF MSB-first, cs high -> word_valid rises
//    SYNC_STAGES+2 cycles later, word_data=0xDEADBEEF, level=1, frame_err=0.
//  2 Frame of 31 bits, then a frame of 33 bits -> two frame_err pulses,
//    level=0, word_valid=0.
//  3 Five good frames 0x1..0x5, word_ready=0, DEPTH=4 -> level=4,
//    overflow=1; pops return 0x1,0x2,0x3,0x4; overflow_clr -> overflow=0.
//  4 FIFO full and word_ready=1 on the cycle a sixth frame's push lands ->
//    no overflow, level=4, head advances by one.
//  5 rst_n low after 16 bits of a frame, released while cs still low, then
//    16 more bits and cs high -> nothing pushed, no frame_err; the next full
//    frame 0x0000A5A5 is captured correctly.
//  6 Back-to-back frames separated by cs high for 2 sck periods, with
//    clk = 8x sck -> every word is captured in order with no errors.

Source files
------------

// File: rtl/spi_rx_capture.sv
// SPI receive front end: synchronises sck/cs/mosi, deserialises MSB-first frames,
// checks the bit count and queues good words in a small FIFO with a valid/ready pop port.
module spi_rx_capture #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sck,
   input  logic                     cs,
   input  logic                     mosi,
   output logic [WIDTH-1:0]         word_data,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     frame_err,
   output logic                     overflow,
   input  logic                     overflow_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, fill;
   logic                   sck_prev, cs_prev, armed;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, cs_rise, cs_fall;

   state_t                 state, state_nx;
   logic [CW-1:0]          bit_cnt, bit_cnt_nx;
   logic [WIDTH-1:0]       sr, sr_nx;
   logic                   push_pend, err_pend, push_nx, err_nx;

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [AW:0]            wr_ptr, rd_ptr;
   logic                   full, pop, wr_en, drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         fill      <= '0;
         sck_prev  <= 1'b0;
         cs_prev   <= 1'b1;
         armed     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
         sck_prev  <= sck_s;
         cs_prev   <= cs_s;
         // only arm once the chain holds real pin samples showing cs high
         armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = ~sck_prev & sck_s;
   assign cs_rise  = ~cs_prev & cs_s;
   assign cs_fall  = cs_prev & ~cs_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         sr        <= '0;
         push_pend <= 1'b0;
         err_pend  <= 1'b0;
      end else begin
         state     <= state_nx;
         bit_cnt   <= bit_cnt_nx;
         sr        <= sr_nx;
         push_pend <= push_nx;
         err_pend  <= err_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      sr_nx      = sr;
      push_nx    = 1'b0;
      err_nx     = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall && armed) begin
               state_nx   = SHIFT;
               bit_cnt_nx = '0;
               sr_nx      = '0;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               if (bit_cnt == CW'(WIDTH)) push_nx = 1'b1;
               else                       err_nx  = 1'b1;
               state_nx = IDLE;
            end else if (sck_rise) begin
               if (bit_cnt == CW'(WIDTH)) begin
                  state_nx = DRAIN;
               end else begin
                  sr_nx      = {sr[WIDTH-2:0], mosi_s};
                  bit_cnt_nx = bit_cnt + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (cs_rise) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign level      = wr_ptr - rd_ptr;
   assign word_valid = (level != '0);
   assign full       = (level == (AW+1)'(DEPTH));
   assign pop        = word_valid & word_ready;
   // a pop in the same cycle frees the slot the push needs
   assign wr_en      = push_pend & (~full | pop);
   assign drop       = push_pend & full & ~pop;
   assign word_data  = word_valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= sr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
         frame_err <= err_pend;
         overflow  <= drop | (overflow & ~overflow_clr);
      end
   end

endmodule

// File: tb/tb_spi_rx_capture.sv
// Directed bench for spi_rx_capture: table of frames plus hand-written
// sequences for latency, overflow, simultaneous push/pop and mid-frame reset.
module tb_spi_rx_capture;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sck = 1'b0;
   logic              cs = 1'b1;
   logic              mosi = 1'b0;
   logic              word_ready = 1'b0;
   logic              overflow_clr = 1'b0;
   logic [WIDTH-1:0]  word_data;
   logic              word_valid;
   logic [2:0]        level;
   logic              frame_err;
   logic              overflow;

   int total = 0;
   int bad = 0;
   int err_cnt = 0;

   typedef struct {
      int          nbits;
      logic [63:0] data;
      int          exp_push;
      int          exp_err;
   } vec_t;

   vec_t vecs [8];

   spi_rx_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .level(level), .frame_err(frame_err), .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err) err_cnt++;

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_bits(input logic [63:0] data, input int n);
      cs = 1'b0;
      wait_clk(4);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = data[i];
         wait_clk(4);
         sck = 1'b1;
         wait_clk(4);
         sck = 1'b0;
      end
      wait_clk(4);
   endtask

   task automatic end_frame();
      cs = 1'b1;
      mosi = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] data, input int n);
      shift_bits(data, n);
      end_frame();
      wait_clk(16);
   endtask

   task automatic pop_chk(input string name, input logic [31:0] exp);
      chk({name, " valid"}, word_valid, 1);
      chk(name, word_data, exp);
      word_ready = 1'b1;
      wait_clk(1);
      word_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int e0;
      int l0;

      vecs[0] = '{32, 64'hDEADBEEF, 1, 0};
      vecs[1] = '{31, 64'h12345678, 0, 1};
      vecs[2] = '{33, 64'h1_2345_6789, 0, 1};
      vecs[3] = '{0,  64'h0, 0, 1};
      vecs[4] = '{32, 64'h12345678, 1, 0};
      vecs[5] = '{32, 64'hFFFFFFFF, 1, 0};
      vecs[6] = '{32, 64'h00000000, 1, 0};
      vecs[7] = '{32, 64'h80000001, 1, 0};

      // reset state
      wait_clk(3);
      chk("rst word_valid", word_valid, 0);
      chk("rst level", level, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst overflow", overflow, 0);
      chk("rst word_data", word_data, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // 1: latency of a good frame
      e0 = err_cnt;
      shift_bits(64'hDEADBEEF, 32);
      end_frame();
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (word_valid) begin
            lat = k;
            break;
         end
      end
      chk("t1 latency", lat, SYNC + 2);
      chk("t1 frame_err", frame_err, 0);
      chk("t1 level", level, 1);
      wait_clk(16);
      pop_chk("t1 data", 32'hDEADBEEF);
      chk("t1 err count", err_cnt - e0, 0);

      // 2: short then long frame, with frame_err latency
      e0 = err_cnt;
      shift_bits(64'h7FFFFFFF, 31);
      end_frame();
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (frame_err) begin
            lat = k;
            break;
         end
      end
      chk("t2 err latency", lat, SYNC + 2);
      wait_clk(16);
      send_frame(64'h1_FFFF_FFFF, 33);
      chk("t2 err count", err_cnt - e0, 2);
      chk("t2 level", level, 0);
      chk("t2 word_valid", word_valid, 0);

      // table-driven frames
      for (int i = 0; i < 8; i++) begin
         e0 = err_cnt;
         l0 = int'(level);
         send_frame(vecs[i].data, vecs[i].nbits);
         chk($sformatf("vec%0d level", i), level, l0 + vecs[i].exp_push);
         chk($sformatf("vec%0d err", i), err_cnt - e0, vecs[i].exp_err);
         if (vecs[i].exp_push != 0) pop_chk($sformatf("vec%0d data", i), vecs[i].data[31:0]);
      end

      // 3: overflow on the fifth frame, then drain and clear
      for (int v = 1; v <= 5; v++) send_frame(64'(v), 32);
      chk("t3 level", level, 4);
      chk("t3 overflow", overflow, 1);
      for (int v = 1; v <= 4; v++) pop_chk($sformatf("t3 pop%0d", v), 32'(v));
      chk("t3 level empty", level, 0);
      chk("t3 overflow sticky", overflow, 1);
      overflow_clr = 1'b1;
      wait_clk(1);
      overflow_clr = 1'b0;
      chk("t3 overflow clr", overflow, 0);

      // 4: full FIFO, pop on the exact push cycle
      for (int v = 0; v < 4; v++) send_frame(64'(32'h10 + v), 32);
      chk("t4 level full", level, 4);
      shift_bits(64'h14, 32);
      end_frame();
      wait_clk(3);
      word_ready = 1'b1;
      wait_clk(1);
      word_ready = 1'b0;
      wait_clk(16);
      chk("t4 overflow", overflow, 0);
      chk("t4 level", level, 4);
      for (int v = 1; v <= 4; v++) pop_chk($sformatf("t4 pop%0d", v), 32'(32'h10 + v));

      // 5: reset mid-frame, released while cs still low
      e0 = err_cnt;
      shift_bits(64'hFFFF, 16);
      rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      shift_bits(64'hFFFF, 16);
      end_frame();
      wait_clk(16);
      chk("t5 level", level, 0);
      chk("t5 word_valid", word_valid, 0);
      chk("t5 err count", err_cnt - e0, 0);
      send_frame(64'h0000A5A5, 32);
      chk("t5 level after", level, 1);
      pop_chk("t5 data", 32'h0000A5A5);
      chk("t5 err after", err_cnt - e0, 0);

      // 6: back-to-back frames, cs high for two sck periods between them
      e0 = err_cnt;
      send_frame(64'hCAFEF00D, 32);
      send_frame(64'h01234567, 32);
      send_frame(64'h89ABCDEF, 32);
      send_frame(64'h5A5A5A5A, 32);
      chk("t6 level", level, 4);
      chk("t6 err count", err_cnt - e0, 0);
      chk("t6 overflow", overflow, 0);
      pop_chk("t6 pop0", 32'hCAFEF00D);
      pop_chk("t6 pop1", 32'h01234567);
      pop_chk("t6 pop2", 32'h89ABCDEF);
      pop_chk("t6 pop3", 32'h5A5A5A5A);
      chk("t6 empty", word_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
